hex_display_mux: RTL and testbench

HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

---
 rtl/hex_display_pkg.sv | 33 +++
 rtl/hex_to_7segment.sv | 14 +
 rtl/hex_display_mux.sv | 132 +++++++++++++
 tb/tb_hex_display_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display multiplexer: segment glyph table,
// the all-segments-off pattern and a counter width helper.
package hex_display_pkg;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs, bit0 = a .. bit6 = g. Element n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_7segment.sv
// Combinational hex digit to active-low seven-segment glyph decoder.
module hex_to_7segment
  import hex_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; every 4-bit code has a glyph.
  always_comb begin
    seg_o = GLYPH_TABLE[digit_i];
  end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver. A prescaler produces one scan tick
// every CLK_DIV clocks; each tick steps to the next digit. The shown value
// comes from a shadow register written by load. Digits can be suppressed by
// leading-zero blanking or by a per-digit blink that follows a slow phase
// derived from the scan ticks. Segment and digit outputs are registered.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int PRESC_W = cnt_width(CLK_DIV);
  localparam int IDX_W   = cnt_width(NUM_DIGITS);
  localparam int BLINK_W = cnt_width(BLINK_DIV);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        scan_q, scan_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

  logic                    tick;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              cur_digit;
  logic                    upper_zero;
  logic                    blink_en;
  logic                    lz_blank;
  logic                    blink_blank;
  logic [6:0]              glyph;

  // Prescaler, scan index and blink timebase advance; tick marks the last prescaler count.
  always_comb begin
    tick        = (presc_q == PRESC_MAX);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    scan_d      = scan_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      scan_d = (scan_q == IDX_MAX) ? '0 : scan_q + 1'b1;
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Shadow capture is independent of the scan tick so a load is never deferred.
  always_comb begin
    shadow_d = load ? value : shadow_q;
  end

  // zero_from[i] is set when shadow digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (shadow_q[4*NUM_DIGITS-4 +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (shadow_q[4*i +: 4] == 4'h0);
    end
  end

  // Select the digit being scanned together with its blanking controls and one-hot enable.
  always_comb begin
    cur_digit  = '0;
    upper_zero = 1'b0;
    blink_en   = 1'b0;
    dig_en_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == IDX_W'(i)) begin
        cur_digit   = shadow_q[4*i +: 4];
        upper_zero  = zero_from[i];
        blink_en    = blink_mask[i];
        dig_en_d[i] = 1'b1;
      end
    end
  end

  hex_to_7segment u_decoder (
    .digit_i (cur_digit),
    .seg_o   (glyph)
  );

  // Digit 0 is exempt from leading-zero blanking so an all-zero value still shows "0".
  always_comb begin
    lz_blank    = blank_lz && (scan_q != '0) && upper_zero;
    blink_blank = blink_en && phase_q;
    seg_d       = (lz_blank || blink_blank) ? SEG_OFF : glyph;
  end

  // State and registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      scan_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      shadow_q    <= '0;
      seg_q       <= SEG_OFF;
      dig_en_q    <= '0;
    end else begin
      presc_q     <= presc_d;
      scan_q      <= scan_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Self-checking bench for hex_display_mux with NUM_DIGITS=4, CLK_DIV=4, BLINK_DIV=2.
module tb_hex_display_mux;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BD = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [4*ND-1:0] value = '0;
  logic            load = 1'b0;
  logic            blank_lz = 1'b0;
  logic [ND-1:0]   blink_mask = '0;
  logic [6:0]      seg;
  logic [ND-1:0]   dig_en;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dig_en     (dig_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int is_legal(input logic [6:0] s);
    if (s == 7'h7F) return 1;
    for (int i = 0; i < 16; i++) if (glyph_tbl[i] == s) return 1;
    return 0;
  endfunction

  // Reference model: k is the number of clock edges since reset release.
  // Before edge k, ticks elapsed = k / CD, scanned digit = ticks % ND,
  // blink phase = (ticks / BD) % 2.
  int         k = 0;
  logic [4*ND-1:0] sh = '0;
  logic [6:0] exp_seg = 7'h7F;
  logic [ND-1:0] exp_dig = '0;

  always @(posedge clk or posedge reset) begin
    int ticks, idx, phase;
    logic lz, bl;
    if (reset) begin
      k = 0;
      sh = '0;
      exp_seg = 7'h7F;
      exp_dig = '0;
    end else begin
      ticks = k / CD;
      idx   = ticks % ND;
      phase = (ticks / BD) % 2;
      lz    = blank_lz && (idx > 0) && ((sh >> (4*idx)) == 0);
      bl    = blink_mask[idx] && (phase == 1);
      exp_dig = ND'(1 << idx);
      exp_seg = (lz || bl) ? 7'h7F : glyph_tbl[sh[4*idx +: 4]];
      if (load) sh = value;
      k++;
    end
  end

  // Every cycle: DUT against model, plus structural output properties.
  always @(posedge clk) begin
    #1;
    chk("seg_vs_model", seg, exp_seg);
    chk("dig_en_vs_model", dig_en, exp_dig);
    chk("dig_en_onehot0", $onehot0(dig_en), 1);
    chk("seg_legal", is_legal(seg), 1);
  end

  task automatic load_val(input logic [4*ND-1:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Sample n cycles; each digit must show its expected glyph and be selected n/ND times.
  task automatic window(input int n, input logic [4*7-1:0] e, input string name);
    int cnt [ND];
    int idx;
    for (int i = 0; i < ND; i++) cnt[i] = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < ND; i++) if (dig_en == ND'(1 << i)) idx = i;
      if (idx < 0) begin
        chk({name, "_onehot"}, dig_en, 0);
      end else begin
        cnt[idx]++;
        chk({name, "_seg"}, seg, e[7*idx +: 7]);
      end
    end
    for (int i = 0; i < ND; i++) chk({name, "_dwell"}, cnt[i], n / ND);
  endtask

  task automatic wait_k(input int m, input int target);
    int n;
    n = 0;
    while ((k % m) != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if ((k % m) != target) chk("wait_k_timeout", k % m, target);
  endtask

  initial begin
    logic [4*ND-1:0] v;
    repeat (3) @(negedge clk);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dig_en", dig_en, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_dig_en", dig_en, 4'b0001);
    chk("first_seg", seg, 7'h40);

    load_val(16'h12AF);
    repeat (16) @(negedge clk);
    window(16, {7'h79, 7'h24, 7'h08, 7'h0E}, "scan_12AF");

    blank_lz = 1'b1;
    load_val(16'h0005);
    repeat (16) @(negedge clk);
    window(16, {7'h7F, 7'h7F, 7'h7F, 7'h12}, "lz_0005");
    load_val(16'h0000);
    repeat (16) @(negedge clk);
    window(16, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "lz_0000");

    // With CLK_DIV=4, BLINK_DIV=2 the phase is 0 whenever digits 0/1 are
    // scanned and 1 whenever digits 2/3 are scanned.
    blank_lz   = 1'b0;
    blink_mask = 4'b0101;
    load_val(16'h1111);
    repeat (16) @(negedge clk);
    window(32, {7'h79, 7'h7F, 7'h79, 7'h79}, "blink_1111");
    blink_mask = 4'b0000;

    // Load on the edge where the tick moves the scan from digit 0 to digit 1.
    wait_k(16, 3);
    value = 16'h3456;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    chk("tick_load_d0_dig", dig_en, 4'b0001);
    chk("tick_load_d0_seg", seg, 7'h79);
    @(negedge clk);
    chk("tick_load_d1_dig", dig_en, 4'b0010);
    chk("tick_load_d1_seg", seg, 7'h12);
    repeat (4) @(negedge clk);
    chk("tick_load_d2_dig", dig_en, 4'b0100);
    chk("tick_load_d2_seg", seg, 7'h19);

    // Reset pulse while digit 2 is being scanned.
    wait_k(16, 9);
    chk("pre_rst_dig", dig_en, 4'b0100);
    reset = 1'b1;
    #1;
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dig", dig_en, 0);
    @(negedge clk);
    chk("mid_rst_seg_hold", seg, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_dig", dig_en, 4'b0001);
    chk("restart_seg", seg, 7'h40);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < ND; i++)
        v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      value = v;
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = ND'($urandom);
    end
    reset = 1'b0;
    load  = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
